axi_slave_read_channel: RTL
===========================

AXI_SLAVE_READ_CHANNEL -- requirements
Module: axi_slave_read_channel

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- ADDR_WIDTH, 32, AR address width.
- DATA_WIDTH, 32, R data width; one 4-byte word per beat.
- LEN_WIDTH, 8, ARLEN width.
- MEM_AW, 10, word-address width of the backing memory; depth is 2^MEM_AW words.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, clock.
- rst_n, in, 1, synchronous active-low reset.
- ARVALID, in, 1, read address valid.
- ARREADY, out, 1, read address ready.
- ARADDR, in, ADDR_WIDTH, byte address of the first beat.
- ARLEN, in, LEN_WIDTH, beats minus one.
- ARSIZE, in, 3, beat size.
- ARBURST, in, 2, burst type.
- RVALID, out, 1, read data valid.
- RREADY, in, 1, master ready.
- RDATA, out, DATA_WIDTH, beat data.
- RRESP, out, 2, beat response.
- RLAST, out, 1, final beat of the burst.
- mem_ren, out, 1, memory read enable.
- mem_raddr, out, MEM_AW, memory word address.
- mem_rdata, in, DATA_WIDTH, memory data, valid exactly one cycle after mem_ren.

REQ-003 Reset SHALL be rst_n, synchronous, active-low; clock SHALL be clk.

Function
REQ-004 States SHALL be IDLE and BURST; ARREADY SHALL be 1 only in IDLE.
- IDLE->BURST on ARVALID&&ARREADY; latch ARADDR, ARLEN, ARSIZE, ARBURST.
- BURST->IDLE on RVALID&&RREADY&&RLAST.
- ARREADY SHALL be 1 in the cycle after that transition.
REQ-005 A burst SHALL deliver exactly ARLEN+1 beats; RLAST SHALL be 1 only with the final beat's RVALID.
REQ-006 Addressing SHALL be INCR.
- Beat k word address = ARADDR[MEM_AW+1:2] + k, truncated to MEM_AW bits.
- ARADDR[1:0] SHALL be ignored.
REQ-007 A beat whose byte address (ARADDR + 4k, ADDR_WIDTH-bit sum) >= 4*2^MEM_AW SHALL return RRESP=2'b11 (DECERR) and RDATA=0.
- No mem_ren SHALL be issued for that beat.
REQ-008 If ARSIZE!=3'b010 or ARBURST!=2'b01, every beat SHALL return RRESP=2'b10 (SLVERR) and RDATA=0, with no mem_ren.
- The beat count SHALL still be ARLEN+1.
REQ-009 All other beats SHALL return RRESP=2'b00 and RDATA=mem_rdata.
REQ-010 R output SHALL come from a 2-entry FIFO holding data, resp and last.
- RVALID = FIFO non-empty.
- Pop on RVALID&&RREADY.
REQ-011 Issue rule: a beat (mem_ren, or a non-memory error beat) SHALL be issued in a BURST cycle only when beats remain to issue and (count + inflight - pop) < 2.
- An error beat SHALL enter the FIFO on the next edge, the same timing as a memory beat.
REQ-012 Latency: with the AR handshake in cycle 0, the first issue SHALL be in cycle 1 and RVALID SHALL be 1 in cycle 3.
- With RREADY held 1, beats SHALL follow on consecutive cycles.
REQ-013 RVALID SHALL hold, and RDATA/RRESP/RLAST SHALL stay stable, while RREADY=0.
- No beat SHALL be lost or duplicated under any RREADY pattern.
REQ-014 ARVALID in BURST SHALL be ignored.
- There SHALL be no outstanding-transaction queue; one burst at a time.
REQ-015 The issued-beat counter and the popped-beat counter SHALL each be LEN_WIDTH+1 bits; ARLEN=255 SHALL yield 256 beats.

Reset
REQ-016 While rst_n=0 at a clk edge, the block SHALL enter IDLE and clear the FIFO, in-flight flag and counters.
- Output values after that edge: ARREADY=1, RVALID=0, RLAST=0, RRESP=0, RDATA=0, mem_ren=0, mem_raddr=0.
REQ-017 Reset mid-burst SHALL discard in-flight memory data.
- No RVALID SHALL appear after reset until a new AR handshake.

Verification
REQ-018 Single beat: memory word[4]=0xDEADBEEF; AR with ARADDR=0x10, ARLEN=0 in cycle 0 -> RVALID in cycle 3, RDATA=0xDEADBEEF, RRESP=0, RLAST=1; ARREADY=1 the cycle after the R handshake.
REQ-019 Streaming: ARADDR=0x0, ARLEN=7, RREADY=1 -> 8 consecutive beats (cycles 3-10) carrying words 0-7; RLAST only on the 8th.
REQ-020 Backpressure: ARLEN=7 with RREADY toggling 1,0,0,1,... -> the same 8 words in order; payload stable while stalled; mem_ren never leaves more than 2 beats buffered or in flight.
REQ-021 Errors:
- ARBURST=2'b00, ARLEN=3 -> 4 beats with RRESP=2'b10, RDATA=0, mem_ren never 1.
- ARADDR=0xFF8, ARLEN=3, MEM_AW=10 -> beats 0-1 OKAY, beats 2-3 DECERR.
REQ-022 Reset mid-burst: rst_n=0 for one cycle at beat 3 of ARLEN=7 -> RVALID=0 and ARREADY=1 after the edge; a new AR with ARLEN=0 returns exactly one correct beat.
REQ-023 Max length: ARLEN=255 with random RREADY -> 256 beats, RLAST on the 256th only.

Source files
------------

// File: rtl/axi_slave_read_channel.sv
// axi_slave_read_channel: single-burst AXI read slave (INCR only) over a
// one-cycle-latency word memory, with a 2-entry R FIFO and DECERR/SLVERR beats.
module axi_slave_read_channel #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 8,
    parameter int MEM_AW     = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ARVALID,
    output logic                  ARREADY,
    input  logic [ADDR_WIDTH-1:0] ARADDR,
    input  logic [LEN_WIDTH-1:0]  ARLEN,
    input  logic [2:0]            ARSIZE,
    input  logic [1:0]            ARBURST,
    output logic                  RVALID,
    input  logic                  RREADY,
    output logic [DATA_WIDTH-1:0] RDATA,
    output logic [1:0]            RRESP,
    output logic                  RLAST,
    output logic                  mem_ren,
    output logic [MEM_AW-1:0]     mem_raddr,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);
    typedef enum logic {IDLE, BURST} state_t;
    state_t state, state_nx;
    logic [ADDR_WIDTH-3:0] base;
    logic [LEN_WIDTH-1:0]  len;
    logic [2:0]            size;
    logic [1:0]            burst;
    logic [LEN_WIDTH:0]    issue_cnt, pop_cnt;
    logic                  pend_v, pend_last;
    logic [1:0]            pend_resp;
    logic [DATA_WIDTH-1:0] f_data [2];
    logic [1:0]            f_resp [2];
    logic                  f_last [2];
    logic                  wr_ptr, rd_ptr;
    logic [1:0]            count;
    logic [ADDR_WIDTH-3:0] beat_wa;
    logic [2:0]            occ;
    logic [1:0]            resp_nx;
    logic                  issue, pop, done, slverr, decerr, unused_addr_bits;
    assign unused_addr_bits = ^ARADDR[1:0];
    // Word-address arithmetic is equivalent to the byte sum since ARADDR[1:0] never carries.
    assign beat_wa  = base + (ADDR_WIDTH-2)'(issue_cnt);
    assign slverr   = size != 3'b010 || burst != 2'b01;
    assign decerr   = |beat_wa[ADDR_WIDTH-3:MEM_AW];
    assign resp_nx  = slverr ? 2'b10 : decerr ? 2'b11 : 2'b00;
    assign RVALID   = count != 2'd0;
    assign pop      = RVALID && RREADY;
    assign done     = pop && pop_cnt == {1'b0, len};
    assign occ      = 3'(count) + 3'(pend_v) - 3'(pop);
    assign issue    = state == BURST && issue_cnt <= {1'b0, len} && occ < 3'd2;
    assign ARREADY  = state == IDLE;
    assign mem_ren  = issue && resp_nx == 2'b00;
    assign mem_raddr = mem_ren ? beat_wa[MEM_AW-1:0] : '0;
    assign RDATA    = RVALID ? f_data[rd_ptr] : '0;
    assign RRESP    = RVALID ? f_resp[rd_ptr] : 2'b00;
    assign RLAST    = RVALID && f_last[rd_ptr];
    always_comb begin
        state_nx = state;
        state_nx = state == IDLE ? (ARVALID ? BURST : IDLE) : (done ? IDLE : BURST);
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            base      <= '0;
            len       <= '0;
            size      <= '0;
            burst     <= '0;
            issue_cnt <= '0;
            pop_cnt   <= '0;
            pend_v    <= 1'b0;
            pend_resp <= 2'b00;
            pend_last <= 1'b0;
            count     <= 2'd0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
        end else begin
            state <= state_nx;
            if (ARVALID && ARREADY) begin
                base      <= ARADDR[ADDR_WIDTH-1:2];
                len       <= ARLEN;
                size      <= ARSIZE;
                burst     <= ARBURST;
                issue_cnt <= '0;
                pop_cnt   <= '0;
            end else begin
                if (issue) issue_cnt <= issue_cnt + 1'b1;
                if (pop) pop_cnt <= pop_cnt + 1'b1;
            end
            // Error beats ride the same one-cycle stage as memory reads.
            pend_v    <= issue;
            pend_resp <= resp_nx;
            pend_last <= issue_cnt == {1'b0, len};
            if (pend_v) wr_ptr <= ~wr_ptr;
            if (pop) rd_ptr <= ~rd_ptr;
            count <= count + 2'(pend_v) - 2'(pop);
        end
    end
    always_ff @(posedge clk) begin
        if (pend_v) begin
            f_data[wr_ptr] <= pend_resp == 2'b00 ? mem_rdata : '0;
            f_resp[wr_ptr] <= pend_resp;
            f_last[wr_ptr] <= pend_last;
        end
    end
endmodule
